// File: rtl/mem_arbiter_pkg.sv
// Shared bus types for the instruction/data memory arbiter: request/response
// structs, arbiter FSM states and the default ibus starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} mem_arb_state_t;

  localparam int MEM_ARB_STARVE_LIMIT = 4;

  // An instruction fetch goes downstream as a plain 4-byte read.
  function automatic dbus_req_t ifetch_req(input logic [31:0] addr);
    dbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = MSIZE4;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and downstream memory buses seen by the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  modport slave  (input  ireq, dreq, mresp, output iresp, dresp, mreq);
  modport master (output ireq, dreq, mresp, input  iresp, dresp, mreq);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (ibus/dbus) arbiter onto one memory bus, dbus priority with
// ibus starvation guard. Define MEM_ARBITER_PERF_EN to build the perf counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [31:0]   perf_igrant,
  output logic [31:0]   perf_dgrant,
  output logic [31:0]   perf_wait
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  mem_arb_state_t state;
  logic [CW-1:0]  starve_cnt;
  dbus_req_t      req_q;
  logic           grant_i, grant_d;
  ibus_resp_t     iresp_c;
  dbus_resp_t     dresp_c;

  always_comb begin
    grant_i = (state == IDLE) && bus.ireq.valid &&
              (!bus.dreq.valid || starve_cnt == LIMIT);
    grant_d = (state == IDLE) && bus.dreq.valid && !grant_i;
  end

  // req_q is the downstream request itself; cleared whenever idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      req_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= IBUSY;
            starve_cnt <= '0;
            req_q      <= ifetch_req(bus.ireq.addr);
          end else if (grant_d) begin
            state       <= DBUSY;
            req_q       <= bus.dreq;
            req_q.valid <= 1'b1;
            if (bus.ireq.valid && starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        IBUSY, DBUSY: begin
          if (bus.mresp.data_ok) begin
            state <= IDLE;
            req_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    iresp_c = '0;
    dresp_c = '0;
    if (state == IBUSY) begin
      iresp_c.addr_ok = bus.mresp.addr_ok;
      iresp_c.data_ok = bus.mresp.data_ok;
      iresp_c.data    = bus.mresp.data[31:0];
    end
    if (state == DBUSY)
      dresp_c = bus.mresp;
  end

  assign bus.mreq  = req_q;
  assign bus.iresp = iresp_c;
  assign bus.dresp = dresp_c;

`ifdef MEM_ARBITER_PERF_EN
  // A requester already being served is not counted as waiting.
  logic waiting;
  assign waiting = (bus.ireq.valid && !grant_i && state != IBUSY) ||
                   (bus.dreq.valid && !grant_d && state != DBUSY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_igrant <= '0;
      perf_dgrant <= '0;
      perf_wait   <= '0;
    end else begin
      perf_igrant <= perf_igrant + 32'(grant_i);
      perf_dgrant <= perf_dgrant + 32'(grant_d);
      perf_wait   <= perf_wait   + 32'(waiting);
    end
  end
`else
  assign perf_igrant = '0;
  assign perf_dgrant = '0;
  assign perf_wait   = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grant order, payload latching, response
// routing, reset abort and perf counters.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] perf_igrant, perf_dgrant, perf_wait;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .perf_igrant(perf_igrant),
    .perf_dgrant(perf_dgrant),
    .perf_wait  (perf_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  byte         exp_side[$];
  logic [63:0] exp_data[$];
  dbus_req_t   exp_req[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.mreq.valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++; if (bus.mreq !== '0) begin miscompares++; $display("FAIL reset_mreq got %h want 0", bus.mreq); end
    vectors++; if (bus.iresp !== '0) begin miscompares++; $display("FAIL reset_iresp got %h want 0", bus.iresp); end
    vectors++; if (bus.dresp !== '0) begin miscompares++; $display("FAIL reset_dresp got %h want 0", bus.dresp); end
    vectors++; if (perf_igrant !== 32'd0) begin miscompares++; $display("FAIL reset_perf_igrant got %0d want 0", perf_igrant); end
    vectors++; if (perf_dgrant !== 32'd0) begin miscompares++; $display("FAIL reset_perf_dgrant got %0d want 0", perf_dgrant); end
    vectors++; if (perf_wait !== 32'd0) begin miscompares++; $display("FAIL reset_perf_wait got %0d want 0", perf_wait); end
    reset = 1'b1;
  endtask

  task automatic test_ifetch();
    bit          ok;
    logic [63:0] e;
    bus.ireq.valid = 1'b1;
    bus.ireq.addr  = 32'h8000_0000;
    tick();
    bus.ireq.valid = 1'b0;
    wait_grant(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ifetch_grant timeout"); end
    vectors++; if (bus.mreq.addr !== 32'h8000_0000) begin miscompares++; $display("FAIL ifetch_addr got %h want 80000000", bus.mreq.addr); end
    vectors++; if (bus.mreq.size !== MSIZE4) begin miscompares++; $display("FAIL ifetch_size got %0d want %0d", bus.mreq.size, MSIZE4); end
    vectors++; if (bus.mreq.strobe !== 8'h00 || bus.mreq.data !== 64'h0) begin
      miscompares++; $display("FAIL ifetch_wr_fields got strobe %h data %h want 0/0", bus.mreq.strobe, bus.mreq.data); end
    exp_data.push_back(64'h13);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin bus.mresp.data_ok = 1'b1; bus.mresp.data = 64'h13; end
      #1;
      vectors++; if (bus.dresp !== '0) begin miscompares++; $display("FAIL ifetch_dresp_zero cyc %0d got %h want 0", c, bus.dresp); end
      if (c == 3) begin
        e = exp_data.pop_front();
        vectors++; if (bus.iresp.data_ok !== 1'b1 || bus.iresp.data !== e[31:0]) begin
          miscompares++; $display("FAIL ifetch_resp got ok %b data %h want 1/%h", bus.iresp.data_ok, bus.iresp.data, e[31:0]); end
      end else begin
        vectors++; if (bus.iresp.data_ok !== 1'b0 || bus.mreq.valid !== 1'b1) begin
          miscompares++; $display("FAIL ifetch_pending cyc %0d got ok %b valid %b want 0/1", c, bus.iresp.data_ok, bus.mreq.valid); end
      end
      tick();
    end
    bus.mresp = '0;
    vectors++; if (bus.mreq.valid !== 1'b0) begin miscompares++; $display("FAIL ifetch_idle got valid %b want 0", bus.mreq.valid); end
  endtask

  // Serve grants with immediate completion, comparing side against exp_side.
  task automatic drain_grants(input string tag);
    bit  ok;
    byte e, got;
    while (exp_side.size() > 0) begin
      wait_grant(ok);
      vectors++; if (!ok) begin
        miscompares++; $display("FAIL %s_timeout remaining %0d", tag, exp_side.size());
        exp_side.delete();
        break;
      end
      e   = exp_side.pop_front();
      got = (bus.mreq.addr == 32'h100) ? "D" : "I";
      vectors++; if (got !== e) begin miscompares++; $display("FAIL %s_order got %c want %c", tag, got, e); end
      bus.mresp.addr_ok = 1'b1;
      bus.mresp.data_ok = 1'b1;
      #1;
      vectors++; if ({bus.iresp.data_ok, bus.dresp.data_ok} !== ((e == "D") ? 2'b01 : 2'b10)) begin
        miscompares++; $display("FAIL %s_route got i%b d%b for %c", tag, bus.iresp.data_ok, bus.dresp.data_ok, e); end
      tick();
      bus.mresp = '0;
    end
  endtask

  task automatic set_both_valid();
    dbus_req_t d;
    d = '{valid: 1'b1, addr: 32'h100, size: MSIZE4, strobe: 8'h00, data: 64'h0};
    bus.dreq       = d;
    bus.ireq.valid = 1'b1;
    bus.ireq.addr  = 32'h8000_0000;
  endtask

  task automatic test_starvation();
    byte order[10] = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
    do_reset();
    foreach (order[i]) exp_side.push_back(order[i]);
    set_both_valid();
    drain_grants("starve");
    bus.ireq.valid = 1'b0;
    bus.dreq.valid = 1'b0;
  endtask

  task automatic test_drop_valid();
    bit        ok;
    dbus_req_t d, e;
    d = '{valid: 1'b1, addr: 32'h100, size: MSIZE4, strobe: 8'hF0, data: 64'hDEAD};
    bus.dreq = d;
    exp_req.push_back(d);
    tick();
    wait_grant(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL drop_grant timeout"); end
    e = exp_req.pop_front();
    tick();
    bus.dreq.valid = 1'b0;
    bus.dreq.addr  = 32'h200;
    bus.dreq.data  = 64'h0;
    for (int c = 1; c <= 3; c++) begin
      vectors++; if (bus.mreq !== e) begin miscompares++; $display("FAIL drop_latch cyc %0d got %h want %h", c, bus.mreq, e); end
      if (c == 3) begin
        bus.mresp.data_ok = 1'b1;
        #1;
        vectors++; if (bus.dresp.data_ok !== 1'b1 || bus.iresp !== '0) begin
          miscompares++; $display("FAIL drop_resp got d%b i%h want 1/0", bus.dresp.data_ok, bus.iresp); end
      end
      tick();
    end
    bus.mresp = '0;
    vectors++; if (bus.mreq.valid !== 1'b0) begin miscompares++; $display("FAIL drop_idle got valid %b want 0", bus.mreq.valid); end
  endtask

  task automatic test_same_cycle_ok();
    bit        ok;
    dbus_req_t d;
    d = '{valid: 1'b1, addr: 32'h300, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    bus.dreq = d;
    tick();
    wait_grant(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL same_grant timeout"); end
    bus.mresp.addr_ok = 1'b1;
    bus.mresp.data_ok = 1'b1;
    #1;
    vectors++; if ({bus.dresp.addr_ok, bus.dresp.data_ok} !== 2'b11) begin
      miscompares++; $display("FAIL same_resp got %b want 11", {bus.dresp.addr_ok, bus.dresp.data_ok}); end
    tick();
    bus.mresp = '0;
    vectors++; if (bus.mreq.valid !== 1'b0) begin miscompares++; $display("FAIL same_gap got valid %b want 0", bus.mreq.valid); end
    tick();
    vectors++; if (bus.mreq.valid !== 1'b1) begin miscompares++; $display("FAIL same_regrant got valid %b want 1", bus.mreq.valid); end
    bus.dreq.valid    = 1'b0;
    bus.mresp.data_ok = 1'b1;
    tick();
    bus.mresp = '0;
  endtask

  task automatic test_reset_mid();
    byte order[5] = '{"D", "D", "D", "D", "I"};
    do_reset();
    set_both_valid();
    tick();
    vectors++; if (bus.mreq.valid !== 1'b1 || bus.mreq.addr !== 32'h100) begin
      miscompares++; $display("FAIL rmid_grant got valid %b addr %h want 1/100", bus.mreq.valid, bus.mreq.addr); end
    bus.ireq.valid = 1'b0;
    bus.dreq.valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++; if (bus.mreq !== '0) begin miscompares++; $display("FAIL rmid_mreq got %h want 0", bus.mreq); end
    bus.mresp.data_ok = 1'b1;
    bus.mresp.data    = 64'h55;
    #1;
    vectors++; if (bus.dresp !== '0 || bus.iresp !== '0) begin
      miscompares++; $display("FAIL rmid_no_fwd got d%h i%h want 0/0", bus.dresp, bus.iresp); end
    tick();
    bus.mresp = '0;
    vectors++; if (bus.mreq.valid !== 1'b0) begin miscompares++; $display("FAIL rmid_idle got valid %b want 0", bus.mreq.valid); end
    foreach (order[i]) exp_side.push_back(order[i]);
    set_both_valid();
    drain_grants("rmid_starve");
    bus.ireq.valid = 1'b0;
    bus.dreq.valid = 1'b0;
  endtask

  task automatic test_perf();
    bit          ok;
    logic [31:0] ei, ed;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin bus.ireq.valid = 1'b1; bus.ireq.addr = 32'h8000_0000 + 32'(i * 4); end
      else begin bus.dreq.valid = 1'b1; bus.dreq.addr = 32'h400; end
      tick();
      bus.ireq.valid = 1'b0;
      bus.dreq.valid = 1'b0;
      wait_grant(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL perf_grant_%0d timeout", i); end
      bus.mresp.data_ok = 1'b1;
      tick();
      bus.mresp = '0;
    end
`ifdef MEM_ARBITER_PERF_EN
    ei = 32'd3; ed = 32'd5;
`else
    ei = 32'd0; ed = 32'd0;
`endif
    vectors++; if (perf_igrant !== ei) begin miscompares++; $display("FAIL perf_igrant got %0d want %0d", perf_igrant, ei); end
    vectors++; if (perf_dgrant !== ed) begin miscompares++; $display("FAIL perf_dgrant got %0d want %0d", perf_dgrant, ed); end
    vectors++; if (perf_wait !== 32'd0) begin miscompares++; $display("FAIL perf_wait got %0d want 0", perf_wait); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.ireq    = '0;
    bus.dreq    = '0;
    bus.mresp   = '0;
    test_reset();
    test_ifetch();
    test_starvation();
    test_drop_valid();
    test_same_cycle_ok();
    test_reset_mid();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
